// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier signals of the shared FP multiplier arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fp_mul_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [32*N-1:0] req_op1;
  logic [32*N-1:0] req_op2;
  logic [N-1:0]    ack;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_res;
  logic            rsp_err;
  logic            busy;
  logic            mul_ready;
  logic [31:0]     mul_op1;
  logic [31:0]     mul_op2;
  logic [31:0]     mul_res;
  logic            mul_done;

  modport slave (
    input  req, req_op1, req_op2,
    input  mul_res, mul_done,
    output ack, rsp_valid, rsp_res, rsp_err,
    output busy, mul_ready, mul_op1, mul_op2
  );

  modport master (
    output req, req_op1, req_op2,
    output mul_res, mul_done,
    input  ack, rsp_valid, rsp_res, rsp_err,
    input  busy, mul_ready, mul_op1, mul_op2
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one single-precision multiplier among N users,
// with a quiet-NaN error response when the multiplier does not answer.
module fp_mul_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  fp_mul_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic [CW-1:0] cnt;

  // Scan downwards so the nearest requester after last wins.
  always_comb begin
    win = last;
    for (int i = N; i >= 1; i--) begin
      if (bus.req[(int'(last) + i) % N]) begin
        win = IW'((int'(last) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last          <= IW'(N - 1);
      owner         <= '0;
      cnt           <= '0;
      bus.ack       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_res   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mul_ready <= 1'b0;
      bus.mul_op1   <= '0;
      bus.mul_op2   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.mul_op1   <= bus.req_op1[32*win +: 32];
            bus.mul_op2   <= bus.req_op2[32*win +: 32];
            bus.ack       <= N'(1) << win;
            bus.mul_ready <= 1'b1;
            bus.busy      <= 1'b1;
            owner         <= win;
            cnt           <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          bus.ack       <= '0;
          bus.mul_ready <= 1'b0;
          cnt           <= cnt + CW'(1);
          // A done seen alongside the start pulse is stale.
          if (!bus.mul_ready) begin
            if (bus.mul_done) begin
              bus.rsp_valid <= N'(1) << owner;
              bus.rsp_res   <= bus.mul_res;
              bus.rsp_err   <= 1'b0;
              state         <= RESP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              bus.rsp_valid <= N'(1) << owner;
              bus.rsp_res   <= 32'h7FC0_0000;
              bus.rsp_err   <= 1'b1;
              state         <= RESP;
            end
          end
        end
        RESP: begin
          bus.rsp_valid <= '0;
          bus.rsp_err   <= 1'b0;
          bus.busy      <= 1'b0;
          last          <= owner;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
